// File: rtl/led_pattern_engine.sv
// LED pattern generator: programmable step prescaler, six tick-driven patterns
// with glitch-free mode/rate reload on step boundaries, PWM brightness gating.
module led_pattern_engine #(
  parameter int WIDTH       = 8,
  parameter int DIV_W       = 24,
  parameter int DEFAULT_DIV = 10_000_000,
  parameter int PWM_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode_load,
  input  logic [2:0]       mode,
  input  logic [DIV_W-1:0] div,
  input  logic [PWM_W-1:0] brightness,
  output logic [WIDTH-1:0] led,
  output logic             step
);

  localparam logic [DIV_W-1:0] DEF_DIV  = DIV_W'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ALT_SEED = WIDTH'({((WIDTH + 1) / 2){2'b01}});
  localparam logic             DIR_LEFT  = 1'b0;
  localparam logic             DIR_RIGHT = 1'b1;

  localparam logic [2:0] M_SHL    = 3'd0;
  localparam logic [2:0] M_SHR    = 3'd1;
  localparam logic [2:0] M_BLINK  = 3'd2;
  localparam logic [2:0] M_ALT    = 3'd3;
  localparam logic [2:0] M_BOUNCE = 3'd4;
  localparam logic [2:0] M_FILL   = 3'd5;

  function automatic logic [WIDTH-1:0] seed_pat(input logic [2:0] m);
    logic [WIDTH-1:0] s;
    s = '0;
    case (m)
      M_SHL, M_BOUNCE: s[0] = 1'b1;
      M_SHR:           s[WIDTH-1] = 1'b1;
      M_BLINK:         s = '1;
      M_ALT:           s = ALT_SEED;
      default:         s = '0;
    endcase
    return s;
  endfunction

  logic [DIV_W-1:0] presc_q, presc_d;
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [2:0]       mode_q, mode_d, mode_nxt_q, mode_nxt_d;
  logic [DIV_W-1:0] div_q, div_d, div_nxt_q, div_nxt_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic             step_q, step_d;
  logic [DIV_W-1:0] div_eff;
  logic             tick;

  always_comb begin
    presc_d    = presc_q;
    pwm_cnt_d  = pwm_cnt_q + 1'b1;
    mode_d     = mode_q;
    div_d      = div_q;
    mode_nxt_d = mode_nxt_q;
    div_nxt_d  = div_nxt_q;
    pend_d     = pend_q;
    pat_d      = pat_q;
    dir_d      = dir_q;

    div_eff = (div_q == '0) ? DIV_W'(1) : div_q;
    tick    = en && (presc_q == div_eff - 1'b1);
    if (en) presc_d = tick ? '0 : presc_q + 1'b1;

    step_d = tick;
    led_d  = pat_q & {WIDTH{pwm_cnt_q < brightness}};

    // A pending reload replaces the advance on its tick: seed only, no step of the new pattern.
    if (tick) begin
      if (pend_q) begin
        mode_d = mode_nxt_q;
        div_d  = div_nxt_q;
        pat_d  = seed_pat(mode_nxt_q);
        dir_d  = DIR_LEFT;
        pend_d = 1'b0;
      end else begin
        case (mode_q)
          M_SHL:            pat_d = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
          M_SHR:            pat_d = {pat_q[0], pat_q[WIDTH-1:1]};
          M_BLINK, M_ALT:   pat_d = ~pat_q;
          M_BOUNCE: begin
            pat_d = (dir_q == DIR_LEFT) ? (pat_q << 1) : (pat_q >> 1);
            if (pat_d[WIDTH-1])  dir_d = DIR_RIGHT;
            else if (pat_d[0])   dir_d = DIR_LEFT;
          end
          M_FILL:           pat_d = (&pat_q) ? '0 : {pat_q[WIDTH-2:0], 1'b1};
          default:          pat_d = '0;
        endcase
      end
    end

    // Capture after the tick logic so a load on a tick cycle stays pending (last load wins).
    if (mode_load) begin
      mode_nxt_d = mode;
      div_nxt_d  = div;
      pend_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q    <= '0;
      pwm_cnt_q  <= '0;
      mode_q     <= M_SHL;
      div_q      <= DEF_DIV;
      mode_nxt_q <= M_SHL;
      div_nxt_q  <= DEF_DIV;
      pend_q     <= 1'b0;
      pat_q      <= WIDTH'(1);
      dir_q      <= DIR_LEFT;
      led_q      <= '0;
      step_q     <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      pwm_cnt_q  <= pwm_cnt_d;
      mode_q     <= mode_d;
      div_q      <= div_d;
      mode_nxt_q <= mode_nxt_d;
      div_nxt_q  <= div_nxt_d;
      pend_q     <= pend_d;
      pat_q      <= pat_d;
      dir_q      <= dir_d;
      led_q      <= led_d;
      step_q     <= step_d;
    end
  end

  assign led  = led_q;
  assign step = step_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Scoreboard bench for led_pattern_engine: a step-index reference model pushes
// expected {step,led} per cycle; an independent monitor pops and compares.
module tb_led_pattern_engine;

  localparam int W     = 8;
  localparam int DW    = 8;
  localparam int DEF   = 5;
  localparam int PW    = 4;

  logic          clk = 1'b0;
  logic          rst, en, mode_load;
  logic [2:0]    mode;
  logic [DW-1:0] div;
  logic [PW-1:0] brightness;
  logic [W-1:0]  led;
  logic          step;

  led_pattern_engine #(.WIDTH(W), .DIV_W(DW), .DEFAULT_DIV(DEF), .PWM_W(PW)) dut (
    .clk(clk), .rst(rst), .en(en), .mode_load(mode_load), .mode(mode),
    .div(div), .brightness(brightness), .led(led), .step(step)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit running = 1'b1;
  logic [W:0] expq[$];
  logic [W:0] mon_e;

  // Reference model: pattern is a pure function of (mode, steps since seed).
  int m_mode, m_k, m_div, m_mn, m_dn, m_el, m_pwm;
  bit m_pend;

  function automatic logic [W-1:0] pat_of(input int md, input int k);
    int p;
    case (md)
      0: return W'(1 << (k % W));
      1: return W'(1 << (W - 1 - (k % W)));
      2: return (k % 2 == 0) ? 8'hFF : 8'h00;
      3: return (k % 2 == 0) ? 8'h55 : 8'hAA;
      4: begin
        p = k % (2 * W - 2);
        return W'(1 << ((p < W) ? p : (2 * W - 2 - p)));
      end
      5: begin
        p = k % (W + 1);
        return W'((1 << p) - 1);
      end
      default: return '0;
    endcase
  endfunction

  function automatic bit tick_next();
    int eff;
    eff = (m_div == 0) ? 1 : m_div;
    return en && (m_el == eff - 1);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_k = 0; m_div = DEF; m_mn = 0; m_dn = DEF;
    m_el = 0; m_pwm = 0; m_pend = 1'b0;
  endtask

  task automatic model_step();
    logic [W-1:0] e_led;
    bit t;
    if (rst) begin
      model_reset();
      expq.push_back('0);
    end else begin
      t = tick_next();
      e_led = (m_pwm < int'(brightness)) ? pat_of(m_mode, m_k) : '0;
      expq.push_back({t, e_led});
      if (t) begin
        m_el = 0;
        if (m_pend) begin
          m_mode = m_mn; m_div = m_dn; m_k = 0; m_pend = 1'b0;
        end else begin
          m_k++;
        end
      end else if (en) begin
        m_el++;
      end
      m_pwm = (m_pwm + 1) % (1 << PW);
      if (mode_load) begin
        m_mn = int'(mode); m_dn = int'(div); m_pend = 1'b1;
      end
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    @(negedge clk);
    mode_load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic load(input int m, input int d);
    mode_load = 1'b1; mode = 3'(m); div = DW'(d);
    cyc();
  endtask

  task automatic wait_pat(input logic [W-1:0] target);
    for (int i = 0; i < 200; i++) begin
      if (pat_of(m_mode, m_k) == target) return;
      cyc();
    end
    n_cmp++; n_err++;
    $display("FAIL wait_pat: pattern %h not reached within 200 clks", target);
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 200; i++) begin
      if (tick_next()) return;
      cyc();
    end
    n_cmp++; n_err++;
    $display("FAIL wait_tick: no tick within 200 clks");
  endtask

  always @(posedge clk) begin
    #1;
    if (running) begin
      if (expq.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL scoreboard: no expectation queued at t=%0t", $time);
      end else begin
        mon_e = expq.pop_front();
        n_cmp++;
        if (led !== mon_e[W-1:0]) begin
          n_err++;
          $display("FAIL led t=%0t: got %h expected %h", $time, led, mon_e[W-1:0]);
        end
        n_cmp++;
        if (step !== mon_e[W]) begin
          n_err++;
          $display("FAIL step t=%0t: got %b expected %b", $time, step, mon_e[W]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    rst = 1'b1; en = 1'b1; mode_load = 1'b0; mode = '0; div = '0; brightness = 4'd15;
    run(3);
    rst = 1'b0;
    run(40);                          // default SHL, dark 1 clk in 16
    load(0, 4);  run(50);             // SHL wrap
    load(4, 2);  run(60);             // BOUNCE ends
    load(0, 3);  wait_pat(8'h08);     // mid-run change to FILL
    load(5, 2);  run(50);
    wait_tick(); load(2, 0); run(20); // load coincident with tick, div 0
    brightness = 4'd4; run(34);
    en = 1'b0; load(3, 2); run(20);   // freeze, load while disabled
    en = 1'b1; run(30);
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      en  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) begin
        mode_load = 1'b1;
        mode = 3'($urandom_range(0, 7));
        div  = DW'($urandom_range(0, 5));
      end
      if ($urandom_range(0, 31) == 0) brightness = PW'($urandom);
      cyc();
    end
    rst = 1'b0; en = 1'b1; brightness = 4'd15;
    load(5, 1); run(12);
    load(1, 3);                       // pending load discarded by reset
    rst = 1'b1; run(2);
    rst = 1'b0; run(30);
    running = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
